// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: beat stream into the feeder plus the skewed lane bus toward the array edge.
// The master modport belongs to the beat producer; the slave modport belongs to the feeder.
interface systolic_feeder_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 8
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [LANES*DW-1:0]   in_a;
  logic [LANES*DW-1:0]   in_w;
  logic [LANES-1:0]      out_f;
  logic [LANES*DW-1:0]   out_a;
  logic [LANES*DW-1:0]   out_w;

  modport master (
    output in_valid, in_last, in_a, in_w,
    input  in_ready, out_f, out_a, out_w
  );

  modport slave (
    input  in_valid, in_last, in_a, in_w,
    output in_ready, out_f, out_a, out_w
  );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: accepts beats of LANES activation/weight pairs and skews them so lane i reaches
// its edge PE i+1 cycles after acceptance. A tile ends with in_last; the feeder then stops
// accepting for LANES cycles (FLUSH) so the last beat drains, and pulses done once.
// Build option: define SYSTOLIC_FEEDER_ZERO_PAD_EN to drive zero data on lanes that are not firing;
// without it a lane holds the last data that fired through it.
module systolic_feeder #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  systolic_feeder_if.slave bus,
  output logic             busy,
  output logic             done
);
  localparam int unsigned CW = $clog2(LANES + 1);

  typedef enum logic [1:0] {StIdle, StStream, StFlush, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire;

  assign bus.in_ready = ~rst & ((state_q == StIdle) | (state_q == StStream));
  assign fire         = bus.in_valid & bus.in_ready;
  assign busy         = (state_q == StStream) | (state_q == StFlush);
  assign done         = (state_q == StDone);

  // State and flush-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tile sequencing: flush lasts exactly LANES cycles so the deepest lane drains its last beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StStream: begin
        if (fire) begin
          if (bus.in_last) begin
            state_d = StFlush;
            cnt_d   = '0;
          end else begin
            state_d = StStream;
          end
        end
      end
      StFlush: begin
        if (cnt_q == CW'(LANES - 1)) state_d = StDone;
        else                         cnt_d   = cnt_q + CW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [i:0]    f_q;
    logic [i:0]    f_in;
    logic [DW-1:0] a_q  [i+1];
    logic [DW-1:0] w_q  [i+1];
    logic [DW-1:0] a_in [i+1];
    logic [DW-1:0] w_in [i+1];

    // Per-stage inputs: stage 0 takes the accepted beat, stage s takes stage s-1.
    always_comb begin
      f_in    = (i+1)'({f_q, fire});
      a_in[0] = bus.in_a[i*DW +: DW];
      w_in[0] = bus.in_w[i*DW +: DW];
      for (int s = 1; s <= i; s++) begin
        a_in[s] = a_q[s-1];
        w_in[s] = w_q[s-1];
      end
    end

    // Lane shift register: fire always shifts; data follows the fire bit it travels with.
    always_ff @(posedge clk) begin
      if (rst) begin
        f_q <= '0;
        for (int s = 0; s <= i; s++) begin
          a_q[s] <= '0;
          w_q[s] <= '0;
        end
      end else begin
        f_q <= f_in;
        for (int s = 0; s <= i; s++) begin
`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
          a_q[s] <= f_in[s] ? a_in[s] : '0;
          w_q[s] <= f_in[s] ? w_in[s] : '0;
`else
          if (f_in[s]) begin
            a_q[s] <= a_in[s];
            w_q[s] <= w_in[s];
          end
`endif
        end
      end
    end

    assign bus.out_f[i]          = f_q[i];
    assign bus.out_a[i*DW +: DW] = a_q[i];
    assign bus.out_w[i*DW +: DW] = w_q[i];
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: table-driven tile scripts, hand-written corner sequences and random traffic,
// all scored every cycle against a history-based model of acceptance, skew and tile timing.
module tb_systolic_feeder;
  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int MAXC  = 4096;

  logic clk = 1'b0;
  logic rst;
  logic busy, done;

  always #5 clk = ~clk;

  systolic_feeder_if #(.LANES(LANES), .DW(DW)) bus ();

  systolic_feeder #(.LANES(LANES), .DW(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  int checks = 0;
  int errors = 0;

  // Model state: what was accepted in every cycle, when reset last hit, when the last beat landed.
  int                  t = 0;
  bit                  fire_h [MAXC];
  logic [LANES*DW-1:0] a_h    [MAXC];
  logic [LANES*DW-1:0] w_h    [MAXC];
  int                  r_last    = -1;
  int                  lastacc   = -1000;
  bit                  streaming = 1'b0;
  bit                  chk_en    = 1'b0;
  bit                  ready_exp;

  // Values seen by the most recent cycle, for the scripted checks.
  logic                s_ready, s_busy, s_done;
  logic [LANES-1:0]    s_f;
  logic [LANES*DW-1:0] s_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, score outputs mid-cycle, then advance the model at the edge.
  task automatic cyc(input logic r, input logic v, input logic l,
                     input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] w);
    int            d, src;
    logic          fe;
    logic [DW-1:0] ea, ew;
    rst          = r;
    bus.in_valid = v;
    bus.in_last  = l;
    bus.in_a     = a;
    bus.in_w     = w;
    @(negedge clk);
    d         = t - lastacc;
    ready_exp = !r && !(d >= 1 && d <= LANES + 1);
    s_ready = bus.in_ready; s_busy = busy; s_done = done; s_f = bus.out_f; s_a = bus.out_a;
    if (chk_en) begin
      check("in_ready", bus.in_ready, ready_exp);
      check("busy", busy, streaming || (d >= 1 && d <= LANES));
      check("done", done, d == LANES + 1);
      for (int i = 0; i < LANES; i++) begin
        src = t - 1 - i;
        fe  = 1'b0;
        ea  = '0;
        ew  = '0;
        if (src > r_last && src >= 0) begin
          fe = fire_h[src];
`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
          if (fe) begin
            ea = a_h[src][i*DW +: DW];
            ew = w_h[src][i*DW +: DW];
          end
`else
          for (int s = src; s > r_last && s >= 0; s--) begin
            if (fire_h[s]) begin
              ea = a_h[s][i*DW +: DW];
              ew = w_h[s][i*DW +: DW];
              break;
            end
          end
`endif
        end
        check($sformatf("out_f[%0d]", i), bus.out_f[i], fe);
        check($sformatf("out_a[%0d]", i), bus.out_a[i*DW +: DW], ea);
        check($sformatf("out_w[%0d]", i), bus.out_w[i*DW +: DW], ew);
      end
    end
    @(posedge clk);
    fire_h[t] = v && ready_exp;
    a_h[t]    = a;
    w_h[t]    = w;
    if (r) begin
      r_last    = t;
      lastacc   = -1000;
      streaming = 1'b0;
      chk_en    = 1'b1;
    end else if (fire_h[t]) begin
      if (l) begin
        lastacc   = t;
        streaming = 1'b0;
      end else begin
        streaming = 1'b1;
      end
    end
    t++;
    #1;
  endtask

  typedef struct {
    logic       v;
    logic       l;
    logic [7:0] b;
    logic       rdy;
    logic       bsy;
    logic       dn;
    logic [3:0] f;
  } vec_t;

  vec_t             tbl [16];
  logic [LANES-1:0] fseq [8];
  logic [DW-1:0]    a0seq [8];
  logic             v, l;
  logic [7:0]       b;

  initial begin
    // Three-beat tile: 0x10..0x12, last on beat 2.
    tbl[0]  = '{1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 4'b0001};
    tbl[2]  = '{1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 4'b0011};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'b0111};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'b1110};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'b1100};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'b1000};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0000};
    // Single-beat tile 0xAB straight from idle.
    tbl[9]  = '{1'b1, 1'b1, 8'hAB, 1'b1, 1'b0, 1'b0, 4'b0000};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'b0001};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'b0010};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'b0100};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'b1000};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0000};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_a     = '0;
    bus.in_w     = '0;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    cyc(1'b1, 1'b1, 1'b0, '1, '1);
    check("rst_ready", s_ready, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);

    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, tbl[k].v, tbl[k].l, {4{tbl[k].b}}, {4{~tbl[k].b}});
      check($sformatf("tbl%0d_ready", k), s_ready, tbl[k].rdy);
      check($sformatf("tbl%0d_busy", k), s_busy, tbl[k].bsy);
      check($sformatf("tbl%0d_done", k), s_done, tbl[k].dn);
      check($sformatf("tbl%0d_f", k), s_f, tbl[k].f);
    end

    // Gap between two beats: every lane shows a one-cycle hole.
    for (int k = 0; k < 8; k++) begin
      v = (k == 0 || k == 2);
      l = (k == 2);
      b = (k == 0) ? 8'h21 : 8'h22;
      cyc(1'b0, v, l, {4{b}}, {4{~b}});
      fseq[k]  = s_f;
      a0seq[k] = s_a[7:0];
      if (k == 1) check("gap_ready", s_ready, 1'b1);
    end
    check("gap_lane0_t1", fseq[1][0], 1'b1);
    check("gap_lane0_t2", fseq[2][0], 1'b0);
    check("gap_lane0_t3", fseq[3][0], 1'b1);
    check("gap_lane3_t4", fseq[4][3], 1'b1);
    check("gap_lane3_t5", fseq[5][3], 1'b0);
    check("gap_lane3_t6", fseq[6][3], 1'b1);
`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
    check("gap_lane0_data", a0seq[2], 8'h00);
`else
    check("gap_lane0_data", a0seq[2], 8'h21);
`endif

    // Valid held through flush: next acceptance is the first idle cycle after done.
    for (int k = 0; k < 8; k++) begin
      b = 8'h40 + 8'(k);
      cyc(1'b0, 1'b1, 1'b1, {4{b}}, {4{~b}});
      fseq[k] = s_f;
      if (k == 6) check("hold_ready_after_done", s_ready, 1'b1);
      if (k == 5) check("hold_ready_in_done", s_ready, 1'b0);
    end
    check("hold_lane0_t6", fseq[6][0], 1'b0);
    check("hold_lane0_t7", fseq[7][0], 1'b1);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 1'b0, '0, '0);

    // Reset in the middle of a tile drops everything in flight.
    cyc(1'b0, 1'b1, 1'b0, {4{8'h51}}, {4{8'h61}});
    cyc(1'b0, 1'b1, 1'b0, {4{8'h52}}, {4{8'h62}});
    cyc(1'b1, 1'b1, 1'b0, {4{8'h53}}, {4{8'h63}});
    for (int k = 3; k < 11; k++) begin
      cyc(1'b0, 1'b0, 1'b0, '0, '0);
      check($sformatf("midrst_f_t%0d", k), s_f, 4'b0000);
      check($sformatf("midrst_busy_t%0d", k), s_busy, 1'b0);
      check($sformatf("midrst_done_t%0d", k), s_done, 1'b0);
    end

    // Random traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      cyc(($urandom_range(99) == 0), ($urandom_range(9) < 7), ($urandom_range(4) == 0),
          LANES*DW'($urandom), LANES*DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
